// File: rtl/seg_pkg.sv
// Shared types, glyph tables and helpers for the multiplexed 7-segment display driver.
package seg_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    CV_IDLE,
    CV_SHIFT,
    CV_DONE
  } cv_state_e;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [7:0] SEG_DASH = 8'hBF;

  // Active-low glyphs, bit 7 is the decimal point and stays dark.
  localparam logic [7:0] DIGIT_GLYPH [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  // "FU11", repeated across the display from the leftmost digit.
  localparam logic [7:0] MSG_GLYPH [0:3] = '{8'h8E, 8'hC1, 8'hF9, 8'hF9};

  // Largest value representable in the given number of decimal digits.
  function automatic int pow10_m1(input int digits);
    int p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return p - 1;
  endfunction

  function automatic logic [7:0] digit_glyph(input bcd_t d);
    return (d > 4'd9) ? SEG_OFF : DIGIT_GLYPH[d];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift/add-3 binary to BCD converter: one load cycle, W shift cycles, one done cycle.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int W      = 6,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int CNT_W   = (W > 1) ? $clog2(W) : 1;
  localparam int MAX_VAL = pow10_m1(DIGITS);

  cv_state_e             state_q, state_d;
  logic [W-1:0]          bin_q, bin_d;
  logic [4*DIGITS-1:0]   work_q, work_d, adj;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    adj     = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] > 4'd4) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
    unique case (state_q)
      CV_IDLE: begin
        if (start) begin
          bin_d   = bin;
          work_d  = '0;
          cnt_d   = '0;
          ovf_d   = int'(bin) > MAX_VAL;
          state_d = CV_SHIFT;
        end
      end
      CV_SHIFT: begin
        work_d = {adj[4*DIGITS-2:0], bin_q[W-1]};
        bin_d  = bin_q << 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(W-1)) state_d = CV_DONE;
      end
      CV_DONE: state_d = CV_IDLE;
      default: state_d = CV_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CV_IDLE;
      bin_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != CV_IDLE);
  assign done = (state_q == CV_DONE);
  assign bcd  = work_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 7-segment driver showing two decimal fields or the "FU11FU11" alarm.
// Optional SEG_BLINK_EN macro adds a blink phase to the alarm message.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int A_W        = 6,
  parameter int A_DIGITS   = 2,
  parameter int B_W        = 10,
  parameter int B_DIGITS   = 3,
  parameter int B_POS      = 3,
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [A_W-1:0]        val_a,
  input  logic [B_W-1:0]        val_b,
  input  logic                  alarm,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            seg
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d, slot_an;
  logic [7:0]            seg_q, seg_d, slot_seg;
  logic [4*A_DIGITS-1:0] bcd_a, bcd_a_q;
  logic [4*B_DIGITS-1:0] bcd_b, bcd_b_q;
  logic                  ovf_a, ovf_a_q, ovf_b, ovf_b_q;
  logic                  busy_a, busy_b, done_a, done_b;
  logic                  tc, blink_on;

  bin2bcd_seq #(.W(A_W), .DIGITS(A_DIGITS)) u_conv_a (
    .clk(clk), .rst_n(rst_n), .start(!busy_a), .bin(val_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a)
  );

  bin2bcd_seq #(.W(B_W), .DIGITS(B_DIGITS)) u_conv_b (
    .clk(clk), .rst_n(rst_n), .start(!busy_b), .bin(val_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .ovf(ovf_b)
  );

`ifdef SEG_BLINK_EN
  localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BL_W-1:0] blink_cnt_q;
  logic            blink_on_q, alarm_q;

  // Outside alarm mode, and on the cycle alarm rises, the phase is held on and the counter cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      alarm_q     <= 1'b0;
    end else begin
      alarm_q <= alarm;
      if (!alarm || !alarm_q) begin
        blink_cnt_q <= '0;
        blink_on_q  <= 1'b1;
      end else if (blink_cnt_q == BL_W'(BLINK_DIV-1)) begin
        blink_cnt_q <= '0;
        blink_on_q  <= !blink_on_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign blink_on = blink_on_q;
`else
  assign blink_on = 1'b1;
`endif

  assign tc = (presc_q == PRE_W'(SCAN_DIV-1));

  // Output pattern for the digit idx_q points at; registered only at the slot boundary.
  always_comb begin
    int   slot, p;
    bcd_t dig;
    logic lead_zero;
    slot      = int'(idx_q);
    p         = 0;
    dig       = '0;
    lead_zero = 1'b1;
    slot_an   = '1;
    slot_seg  = SEG_OFF;
    if (alarm) begin
      if (blink_on) begin
        slot_an[idx_q] = 1'b0;
        slot_seg       = MSG_GLYPH[2'((NUM_DIGITS-1-slot) % 4)];
      end
    end else if (slot < A_DIGITS) begin
      p = slot;
      for (int j = 0; j < A_DIGITS; j++) begin
        if (j == p) dig = bcd_a_q[4*j +: 4];
        if (j >= p && bcd_a_q[4*j +: 4] != 4'd0) lead_zero = 1'b0;
      end
      if (ovf_a_q) begin
        slot_an[idx_q] = 1'b0;
        slot_seg       = SEG_DASH;
      end else if (!(lead_zero && p != 0)) begin
        slot_an[idx_q] = 1'b0;
        slot_seg       = digit_glyph(dig);
      end
    end else if (slot >= B_POS && slot < B_POS + B_DIGITS) begin
      p = slot - B_POS;
      for (int j = 0; j < B_DIGITS; j++) begin
        if (j == p) dig = bcd_b_q[4*j +: 4];
        if (j >= p && bcd_b_q[4*j +: 4] != 4'd0) lead_zero = 1'b0;
      end
      if (ovf_b_q) begin
        slot_an[idx_q] = 1'b0;
        slot_seg       = SEG_DASH;
      end else if (!(lead_zero && p != 0)) begin
        slot_an[idx_q] = 1'b0;
        slot_seg       = digit_glyph(dig);
      end
    end
  end

  // idx_q names the digit driven at the next terminal count, so the first slot is digit 0.
  always_comb begin
    presc_d = tc ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    an_d    = an_q;
    seg_d   = seg_q;
    if (tc) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS-1)) ? '0 : idx_q + 1'b1;
      an_d  = slot_an;
      seg_d = slot_seg;
    end
  end

  // NOTE: the BCD snapshots are reset too, so nothing stale or partial can reach the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= SEG_OFF;
      bcd_a_q <= '0;
      ovf_a_q <= 1'b0;
      bcd_b_q <= '0;
      ovf_b_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      if (done_a) begin
        bcd_a_q <= bcd_a;
        ovf_a_q <= ovf_a;
      end
      if (done_b) begin
        bcd_b_q <= bcd_b;
        ovf_b_q <= ovf_b;
      end
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
